param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bus width (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count (any integer >=2, not restricted to powers of 2).
REQ-003 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameters AF_THRESH, default DEPTH-2, and AE_THRESH, default 2, as almost-full/almost-empty levels.
REQ-005 SHALL have clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have flush  in  1  synchronous clear of contents.
REQ-008 SHALL have wr_en  in  1  write request; wr_data  in  DATA_WIDTH  write data.
REQ-009 SHALL have full  out  1, and almost_full  out  1, meaning level>=AF_THRESH.
REQ-010 SHALL have rd_en  in  1  read request (pop acknowledge in FWFT mode).
REQ-011 SHALL have rd_data  out  DATA_WIDTH, and rd_valid  out  1, meaning rd_data holds a popped/head word.
REQ-012 SHALL have empty  out  1, and almost_empty  out  1, meaning level<=AE_THRESH.
REQ-013 SHALL have level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-014 SHALL have overflow  out  1, underflow  out  1 (sticky error flags), and err_clr  in  1.

Function
REQ-015 Write accepted iff wr_en && !full && !flush; data stored at wr_ptr; wr_ptr advances.
REQ-016 Read accepted iff rd_en && !empty && !flush; rd_ptr advances.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0; no extra-bit scheme; occupancy tracked by a level counter.
REQ-018 Level: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read+write or neither.
REQ-019 full = (level==DEPTH); empty = (level==0); both derived from registered level, no combinational path from wr_en/rd_en.
REQ-020 Write to full: ignored, no state change; read from empty: ignored, no state change.
REQ-021 FWFT=0: rd_data registered, loaded with the head word on the clock edge accepting the read; rd_valid high exactly the cycle after each accepted read; rd_data holds otherwise.
REQ-022 FWFT=1: rd_data = head entry whenever !empty; rd_valid = !empty; first word visible the cycle after its write into an empty FIFO; rd_en pops it.
REQ-023 Flush: next cycle level=0, pointers=0, rd_valid=0, rd_data=0; flush overrides same-cycle wr_en/rd_en; memory contents not cleared.
REQ-024 Simultaneous read+write at level 0 (FWFT=0): read rejected, write accepted; at level DEPTH: write rejected, read accepted.

Reset
REQ-025 rst_n low SHALL asynchronously force wr_ptr=0, rd_ptr=0, level=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-026 Outputs during/after reset: empty=1, full=0, almost_empty=1, almost_full=0 (for AF_THRESH>0); memory array not reset.
REQ-027 Reset asserted mid-operation SHALL discard all contents; the first post-reset write behaves as into an empty FIFO.

Configuration
REQ-028 Macro PARAM_SYNC_FIFO_ERR_EN defined: overflow sets on wr_en&&full, underflow sets on rd_en&&empty (both sticky); err_clr clears both next cycle; a same-cycle set wins over err_clr.
REQ-029 Macro PARAM_SYNC_FIFO_ERR_EN undefined: overflow and underflow ports remain, tied to 0; err_clr ignored; no error logic synthesised.

Verification
REQ-030 DEPTH=5, FWFT=0: write 0x11..0x55 -> full=1, level=5, almost_full=1; 6th write 0x66 ignored; 5 reads return 0x11..0x55, rd_valid one cycle after each rd_en.
REQ-031 DEPTH=5: 12 interleaved write/read pairs crossing index 4->0 twice -> data in order, level never exceeds 2, no errors.
REQ-032 FWFT=1: single write 0xA5 into empty -> next cycle empty=0, rd_valid=1, rd_data=0xA5 with no rd_en; rd_en pops it -> empty=1 next cycle.
REQ-033 Level 3, same cycle wr_en+rd_en -> level stays 3; level 3 plus flush+wr_en -> level=0, empty=1, written word discarded.
REQ-034 ERR_EN defined: rd_en on empty -> underflow=1 and held; err_clr -> 0 next cycle; wr_en at full with err_clr -> overflow=1.
REQ-035 rst_n pulsed low mid-burst at level 4 -> immediately level=0, empty=1, rd_valid=0; subsequent write/read of 0x3C returns 0x3C.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered-read or first-word-fall-through output.
// Define PARAM_SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they are tied low.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         err_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Wrap explicitly so non-power-of-two depths work without an extra pointer bit.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full         = (level_q == LVL_FULL);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LVL_AF);
    assign almost_empty = (level_q <= LVL_AE);
    assign level        = level_q;

    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is exposed directly; zero when nothing is held.
            assign rd_data  = empty ? '0 : mem[rd_ptr];
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

`ifdef PARAM_SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // A new error in the same cycle as err_clr must remain visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end else if (err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a DEPTH=5 registered-read instance and a DEPTH=4 FWFT instance.
module tb_param_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       err_clr;
    logic       full;
    logic       almost_full;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic [2:0] level;
    logic       overflow;
    logic       underflow;

    logic       f_flush;
    logic       f_wr_en;
    logic [7:0] f_wr_data;
    logic       f_rd_en;
    logic       f_full;
    logic       f_almost_full;
    logic [7:0] f_rd_data;
    logic       f_rd_valid;
    logic       f_empty;
    logic       f_almost_empty;
    logic [2:0] f_level;
    logic       f_overflow;
    logic       f_underflow;

    int checks = 0;
    int errors = 0;

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .full(f_full), .almost_full(f_almost_full), .rd_en(f_rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_almost_empty), .level(f_level),
        .overflow(f_overflow), .underflow(f_underflow), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;
        f_flush = 1'b0; f_wr_en = 1'b0; f_wr_data = '0; f_rd_en = 1'b0;
        #12;
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_f_empty", 32'(f_empty), 1);
        check("rst_f_full", 32'(f_full), 0);
        check("rst_f_af", 32'(f_almost_full), 0);
        check("rst_f_ae", 32'(f_almost_empty), 1);
        check("rst_f_rd_valid", 32'(f_rd_valid), 0);
        check("rst_f_rd_data", 32'(f_rd_data), 0);
        check("rst_f_level", 32'(f_level), 0);
        check("rst_f_ovf", 32'(f_overflow), 0);
        check("rst_f_udf", 32'(f_underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fill DEPTH=5 with 0x11..0x55, checking the almost-full/almost-empty boundary at 2/3.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h11 * (i + 1));
            step();
            check("fill_level", 32'(level), 32'(i + 1));
            if (i == 1) begin
                check("lvl2_af", 32'(almost_full), 0);
                check("lvl2_ae", 32'(almost_empty), 1);
            end
            if (i == 2) begin
                check("lvl3_af", 32'(almost_full), 1);
                check("lvl3_ae", 32'(almost_empty), 0);
            end
        end
        check("fill_full", 32'(full), 1);
        check("fill_af", 32'(almost_full), 1);

        wr_data = 8'h66; err_clr = 1'b1;
        step();
        wr_en = 1'b0; err_clr = 1'b0;
        check("ovr_level", 32'(level), 5);
        check("ovr_full", 32'(full), 1);
`ifdef PARAM_SYNC_FIFO_ERR_EN
        check("ovf_set_wins", 32'(overflow), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
`else
        check("ovf_tied", 32'(overflow), 0);
`endif

        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
            check("rd_valid", 32'(rd_valid), 1);
            check("rd_data", 32'(rd_data), 32'(8'(8'h11 * (i + 1))));
            check("rd_level", 32'(level), 32'(4 - i));
            step();
            check("rd_valid_drop", 32'(rd_valid), 0);
            check("rd_data_hold", 32'(rd_data), 32'(8'(8'h11 * (i + 1))));
        end
        check("drain_empty", 32'(empty), 1);

        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("udr_rd_valid", 32'(rd_valid), 0);
        check("udr_rd_data", 32'(rd_data), 8'h55);
        check("udr_level", 32'(level), 0);
`ifdef PARAM_SYNC_FIFO_ERR_EN
        check("udf_set", 32'(underflow), 1);
        step();
        check("udf_held", 32'(underflow), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("udf_cleared", 32'(underflow), 0);
`else
        check("udf_tied", 32'(underflow), 0);
`endif

        // Streaming through the pointer wrap twice with one word in flight.
        wr_en = 1'b1; wr_data = 8'hA0;
        step();
        for (int k = 1; k < 12; k++) begin
            wr_data = 8'(8'hA0 + k);
            rd_en = 1'b1;
            step();
            check("wrap_data", 32'(rd_data), 32'(8'(8'hA0 + k - 1)));
            check("wrap_valid", 32'(rd_valid), 1);
            check("wrap_level", 32'(level), 1);
        end
        wr_en = 1'b0;
        step();
        rd_en = 1'b0;
        check("wrap_last", 32'(rd_data), 8'hAB);
        check("wrap_level0", 32'(level), 0);
        check("wrap_no_ovf", 32'(overflow), 0);
        check("wrap_no_udf", 32'(underflow), 0);

        // Level 3, simultaneous read+write, then flush overriding a write.
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_data = 8'(i);
            step();
        end
        wr_data = 8'h04; rd_en = 1'b1;
        step();
        check("rw_level", 32'(level), 3);
        check("rw_data", 32'(rd_data), 8'h01);
        wr_data = 8'h99; rd_en = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; wr_en = 1'b0;
        check("flush_level", 32'(level), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_rd_valid", 32'(rd_valid), 0);
        check("flush_rd_data", 32'(rd_data), 0);
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("post_flush_data", 32'(rd_data), 8'h77);
        check("post_flush_level", 32'(level), 0);

        // Read+write at empty: write only. At full: read only.
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hC1;
        step();
        rd_en = 1'b0;
        check("rw_empty_level", 32'(level), 1);
        check("rw_empty_valid", 32'(rd_valid), 0);
        for (int i = 2; i <= 5; i++) begin
            wr_data = 8'(8'hC0 + i);
            step();
        end
        check("refill_full", 32'(full), 1);
        wr_data = 8'hC6; rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("rw_full_level", 32'(level), 4);
        check("rw_full_valid", 32'(rd_valid), 1);
        check("rw_full_data", 32'(rd_data), 8'hC1);
        check("rw_full_flag", 32'(full), 0);

        // Asynchronous reset in the middle of a write burst at level 4.
        wr_en = 1'b1; wr_data = 8'hEE;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level", 32'(level), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_rd_valid", 32'(rd_valid), 0);
        check("arst_full", 32'(full), 0);
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("post_rst_data", 32'(rd_data), 8'h3C);
        check("post_rst_valid", 32'(rd_valid), 1);
        check("post_rst_level", 32'(level), 0);

        // First-word-fall-through instance.
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        step();
        f_wr_en = 1'b0;
        check("fwft_empty", 32'(f_empty), 0);
        check("fwft_valid", 32'(f_rd_valid), 1);
        check("fwft_data", 32'(f_rd_data), 8'hA5);
        step();
        check("fwft_hold", 32'(f_rd_data), 8'hA5);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        check("fwft_pop_empty", 32'(f_empty), 1);
        check("fwft_pop_valid", 32'(f_rd_valid), 0);
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        step();
        f_wr_data = 8'h3C;
        step();
        f_wr_en = 1'b0;
        check("fwft_head1", 32'(f_rd_data), 8'h5A);
        check("fwft_level2", 32'(f_level), 2);
        f_rd_en = 1'b1;
        step();
        check("fwft_head2", 32'(f_rd_data), 8'h3C);
        step();
        f_rd_en = 1'b0;
        check("fwft_final_empty", 32'(f_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
